// File: rtl/uart_mem_loader_pkg.sv
// Shared definitions for the UART boot loader/dumper: FSM state encodings,
// byte-lane helpers and counter-width functions.
package uart_mem_loader_pkg;

  // 4-bit state encodings, also exported on the debug state port
  typedef enum logic [3:0] {
    S_LOAD = 4'd0,
    S_RUN  = 4'd1,
    S_RD   = 4'd2,
    S_WAIT = 4'd3,
    S_TX   = 4'd4,
    S_CSUM = 4'd5,
    S_DONE = 4'd6
  } state_t;

  localparam int STATE_W = 4;

  // Ceiling log2; clog2(1) = 0
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Number of bytes per memory word
  function automatic int bytes_of(input int data_w);
    return data_w / 8;
  endfunction

  // Lane counter width; at least one bit even for single-byte words
  function automatic int lane_w(input int bytes);
    return (clog2(bytes) < 1) ? 1 : clog2(bytes);
  endfunction

endpackage

// File: rtl/mem_loader_ser.sv
// Parallel-load word shift register that hands out its bytes LSB first over
// a valid/ready handshake. A load arms BYTES transfers; byte_last flags the
// handshake that drains the final byte.
module mem_loader_ser #(
  parameter int DATA_W = 64,
  parameter int BYTES  = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  output logic [7:0]        byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              byte_last
);

  logic [DATA_W-1:0] sh_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              fire;

  assign byte_data  = sh_reg[7:0];
  assign byte_valid = (cnt_reg != '0);
  assign fire       = byte_valid && byte_ready;
  assign byte_last  = fire && (cnt_reg == CNT_W'(1));

  // Load a fresh word, or shift out one byte per accepted handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_reg  <= '0;
      cnt_reg <= '0;
    end else if (load) begin
      sh_reg  <= load_data;
      cnt_reg <= CNT_W'(BYTES);
    end else if (fire) begin
      sh_reg  <= sh_reg >> 8;
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_mem_loader.sv
// Boot loader/dumper between the UART byte stream and data-memory port B.
// Packs received bytes little-endian into words and writes LOAD_WORDS words
// from address 0, pulses flsh, then on a sys_fin rising edge reads DUMP_WORDS
// words from DUMP_BASE and streams them back as bytes.
// Optional build macro: LOADER_CHECKSUM_EN appends a mod-256 sum byte.
module uart_mem_loader
  import uart_mem_loader_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 14,
  parameter int LOAD_WORDS = 1024,
  parameter int DUMP_BASE  = 0,
  parameter int DUMP_WORDS = 256,
  parameter int RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              sys_fin,
  output logic              flsh,
  output logic [3:0]        state
);

  localparam int BYTES  = bytes_of(DATA_W);
  localparam int LANE_W = lane_w(BYTES);
  localparam int CNT_W  = clog2(BYTES + 1);

  localparam logic [ADDR_W-1:0] LAST_LOAD = ADDR_W'(LOAD_WORDS - 1);
  localparam logic [ADDR_W-1:0] LAST_DUMP = ADDR_W'(DUMP_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(DUMP_BASE);
  localparam logic [1:0]        WAIT_LAST = 2'(RD_LAT - 1);

  state_t state_reg, state_next;

  logic [7:0]        lane_reg [BYTES];
  logic [LANE_W-1:0] lane_cnt_reg;
  logic [DATA_W-1:0] word_next;
  logic [DATA_W-1:0] wr_word_reg;
  logic              wr_pend_reg;
  logic [ADDR_W-1:0] word_cnt_reg;
  logic [ADDR_W-1:0] dump_cnt_reg;
  logic [1:0]        wait_cnt_reg;
  logic              sys_fin_reg, sys_fin_d_reg;
  logic              flsh_reg;

  logic              load_byte, lane_last, fin_edge;
  logic              ser_load, ser_valid, ser_ready, ser_last;
  logic [7:0]        ser_byte;

  assign load_byte = (state_reg == S_LOAD) && rx_valid;
  assign lane_last = (lane_cnt_reg == LANE_W'(BYTES - 1));
  assign fin_edge  = sys_fin_reg && !sys_fin_d_reg;
  assign ser_load  = (state_reg == S_WAIT) && (wait_cnt_reg == WAIT_LAST);
  assign ser_ready = (state_reg == S_TX) && tx_ready;
  assign flsh      = flsh_reg;
  assign state     = state_reg;

  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      // Capture each received byte into its own little-endian lane
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          lane_reg[gi] <= '0;
        else if (load_byte && (lane_cnt_reg == LANE_W'(gi)))
          lane_reg[gi] <= rx_data;
      end
    end
  endgenerate

  // Completed word: stored lanes with the byte arriving now in the top lane
  always_comb begin
    word_next = '0;
    for (int i = 0; i < BYTES; i++)
      word_next[i*8 +: 8] = lane_reg[i];
    word_next[(BYTES-1)*8 +: 8] = rx_data;
  end

  // State register, pack/write pipeline, counters and sys_fin sampling
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_LOAD;
      lane_cnt_reg  <= '0;
      wr_word_reg   <= '0;
      wr_pend_reg   <= 1'b0;
      word_cnt_reg  <= '0;
      dump_cnt_reg  <= '0;
      wait_cnt_reg  <= '0;
      sys_fin_reg   <= 1'b0;
      sys_fin_d_reg <= 1'b0;
      flsh_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sys_fin_reg   <= sys_fin;
      sys_fin_d_reg <= sys_fin_reg;
      flsh_reg      <= (state_reg == S_LOAD) && (state_next == S_RUN);
      // Write is issued the cycle after the last lane arrives, so a byte in
      // that write cycle can already start lane 0 of the next word.
      wr_pend_reg   <= load_byte && lane_last;
      if (load_byte) begin
        lane_cnt_reg <= lane_last ? '0 : lane_cnt_reg + LANE_W'(1);
        if (lane_last)
          wr_word_reg <= word_next;
      end
      if ((state_reg == S_LOAD) && wr_pend_reg && (word_cnt_reg != LAST_LOAD))
        word_cnt_reg <= word_cnt_reg + ADDR_W'(1);
      if (state_reg == S_RD)
        wait_cnt_reg <= '0;
      else if (state_reg == S_WAIT)
        wait_cnt_reg <= wait_cnt_reg + 2'd1;
      if ((state_reg == S_TX) && ser_last && (dump_cnt_reg != LAST_DUMP))
        dump_cnt_reg <= dump_cnt_reg + ADDR_W'(1);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_reg;

  // Running mod-256 sum of every data byte the transmitter accepts
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      csum_reg <= '0;
    else if ((state_reg == S_TX) && ser_valid && tx_ready)
      csum_reg <= csum_reg + ser_byte;
  end
`endif

  // Next-state decode and port B / transmitter output drive
  always_comb begin
    state_next = state_reg;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_din    = '0;
    tx_valid   = 1'b0;
    tx_data    = '0;
    case (state_reg)
      S_LOAD: begin
        if (wr_pend_reg) begin
          mem_en   = 1'b1;
          mem_we   = 1'b1;
          mem_addr = word_cnt_reg;
          mem_din  = wr_word_reg;
          if (word_cnt_reg == LAST_LOAD)
            state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (fin_edge)
          state_next = S_RD;
      end
      S_RD: begin
        mem_en     = 1'b1;
        mem_addr   = BASE_A + dump_cnt_reg;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_reg == WAIT_LAST)
          state_next = S_TX;
      end
      S_TX: begin
        tx_valid = ser_valid;
        tx_data  = ser_byte;
        if (ser_last) begin
          if (dump_cnt_reg != LAST_DUMP)
            state_next = S_RD;
          else
`ifdef LOADER_CHECKSUM_EN
            state_next = S_CSUM;
`else
            state_next = S_DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum_reg;
        if (tx_ready)
          state_next = S_DONE;
      end
`endif
      S_DONE: state_next = S_DONE;
      default: state_next = S_DONE;
    endcase
  end

  mem_loader_ser #(
    .DATA_W (DATA_W),
    .BYTES  (BYTES),
    .CNT_W  (CNT_W)
  ) u_ser (
    .clk        (clk),
    .rst        (rst),
    .load       (ser_load),
    .load_data  (mem_dout),
    .byte_data  (ser_byte),
    .byte_valid (ser_valid),
    .byte_ready (ser_ready),
    .byte_last  (ser_last)
  );

endmodule

// File: tb/tb_uart_mem_loader.sv
// Self-checking bench for uart_mem_loader (16-bit words, 2 loaded, 2 dumped).
// Table vectors cover the load/dump basics; hand sequences cover reset,
// sys_fin already high, and mid-load reset; randomized runs are checked
// against a byte-level reference model.
module tb_uart_mem_loader;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 4;
  localparam int LOAD_WORDS = 2;
  localparam int DUMP_BASE  = 0;
  localparam int DUMP_WORDS = 2;
  localparam int RD_LAT     = 1;
  localparam int BYTES      = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic              sys_fin;
  logic              flsh;
  logic [3:0]        state;

  uart_mem_loader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LOAD_WORDS(LOAD_WORDS),
    .DUMP_BASE(DUMP_BASE), .DUMP_WORDS(DUMP_WORDS), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .sys_fin(sys_fin),
    .flsh(flsh), .state(state)
  );

  always #5 clk = ~clk;

  // Port B memory with a one-cycle registered read
  logic [DATA_W-1:0] ram [2**ADDR_W];
  logic [DATA_W-1:0] ram_dout;
  assign mem_dout = ram_dout;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      else        ram_dout      <= ram[mem_addr];
    end
  end

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    int          gap;
    logic [15:0] w0, w1;
  } vec_t;

  wr_t        wr_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         flsh_cycles = 0;
  int         rdy_mode = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  vec_t       tbl [3];
  logic [7:0] bytes_in [4];
  logic [15:0] ref_mem [2**ADDR_W];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Observe writes, accepted tx bytes, flsh and stall stability each cycle
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("tx_hold_valid", {31'd0, tx_valid}, 32'd1);
        chk("tx_hold_data", {24'd0, tx_data}, {24'd0, prev_data});
      end
      if (mem_en && mem_we) wr_q.push_back('{mem_addr, mem_din});
      if (tx_valid && tx_ready) tx_q.push_back(tx_data);
      if (flsh) flsh_cycles++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  // Transmitter ready pattern: 0 toggle, 1 random, 2 always ready
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0)      tx_ready = ~tx_ready;
      else if (rdy_mode == 1) tx_ready = 1'($urandom_range(0, 1));
      else                    tx_ready = 1'b1;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    wr_q.delete();
    tx_q.delete();
    flsh_cycles = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", {28'd0, state}, 32'd0);
    chk("rst_mem_en", {30'd0, mem_en, mem_we}, 32'd0);
    chk("rst_tx", {23'd0, tx_valid, tx_data}, 32'd0);
    chk("rst_addr_din", {12'd0, mem_addr, mem_din}, 32'd0);
    chk("rst_flsh", {31'd0, flsh}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_state", {28'd0, state}, 32'd0);
    chk("post_rst_mem_en", {31'd0, mem_en}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget, input string nm);
    int i;
    i = 0;
    while (state !== s && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(nm, {28'd0, state}, {28'd0, s});
    @(posedge clk);
    #1;
  endtask

  // Reference: pack bytes little-endian, derive expected writes and dump bytes
  task automatic load_and_check(input int gap_max, input string tag);
    for (int i = 0; i < 4; i++)
      send(bytes_in[i], (gap_max < 0) ? -gap_max : int'($urandom_range(0, gap_max)));
    wait_state(4'd1, 60, {tag, "_run"});
    for (int w = 0; w < LOAD_WORDS; w++) begin
      ref_mem[w] = 16'(bytes_in[2*w]) + 16'(bytes_in[2*w+1]) * 16'd256;
    end
    chk({tag, "_nwrites"}, wr_q.size(), LOAD_WORDS);
    for (int w = 0; w < LOAD_WORDS && w < wr_q.size(); w++) begin
      chk({tag, "_waddr"}, {28'd0, wr_q[w].a}, w);
      chk({tag, "_wdata"}, {16'd0, wr_q[w].d}, {16'd0, ref_mem[w]});
    end
    chk({tag, "_flsh_cycles"}, flsh_cycles, 1);
  endtask

  task automatic dump_and_check(input string tag);
    int sum;
    exp_q.delete();
    sum = 0;
    for (int w = 0; w < DUMP_WORDS; w++)
      for (int k = 0; k < BYTES; k++) begin
        exp_q.push_back(8'((ref_mem[DUMP_BASE + w] >> (8 * k)) & 16'hFF));
        sum = sum + int'((ref_mem[DUMP_BASE + w] >> (8 * k)) & 16'hFF);
      end
`ifdef LOADER_CHECKSUM_EN
    exp_q.push_back(8'(sum % 256));
`endif
    tx_q.delete();
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    sys_fin = 1'b1;
    wait_state(4'd6, 300, {tag, "_done"});
    sys_fin = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk({tag, "_stay_done"}, {28'd0, state}, 32'd6);
    chk({tag, "_ntx"}, tx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk({tag, "_txbyte"}, (i < tx_q.size()) ? {24'd0, tx_q[i]} : 32'hFFFF_FFFF,
          {24'd0, exp_q[i]});
    $display("TXN %s dump bytes=%0d first=%0h sum_ref=%0h", tag, tx_q.size(),
             (tx_q.size() > 0) ? tx_q[0] : 8'h00, sum % 256);
  endtask

  initial begin
    logic [15:0] old0;
    for (int i = 0; i < 2**ADDR_W; i++) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end
    ram_dout = '0;
    rst = 1'b1;
    rx_data = '0;
    rx_valid = 1'b0;
    sys_fin = 1'b0;

    tbl[0] = '{8'h34, 8'h12, 8'h78, 8'h56, 3, 16'h1234, 16'h5678};
    tbl[1] = '{8'h34, 8'h12, 8'h78, 8'h56, 0, 16'h1234, 16'h5678};
    tbl[2] = '{8'hFF, 8'h00, 8'h01, 8'h80, 1, 16'h00FF, 16'h8001};

    // Table vectors: load with fixed gaps, then dump with toggling ready
    for (int v = 0; v < 3; v++) begin
      do_reset();
      bytes_in[0] = tbl[v].b0;
      bytes_in[1] = tbl[v].b1;
      bytes_in[2] = tbl[v].b2;
      bytes_in[3] = tbl[v].b3;
      load_and_check(-tbl[v].gap, $sformatf("vec%0d", v));
      chk("vec_w0_table", {16'd0, ref_mem[0]}, {16'd0, tbl[v].w0});
      chk("vec_w1_table", {16'd0, ref_mem[1]}, {16'd0, tbl[v].w1});
      rdy_mode = 0;
      dump_and_check($sformatf("vec%0d", v));
    end

    // sys_fin high through reset and load must not start a dump
    sys_fin = 1'b1;
    do_reset();
    bytes_in[0] = 8'h11; bytes_in[1] = 8'h22; bytes_in[2] = 8'h33; bytes_in[3] = 8'h44;
    load_and_check(-1, "finhigh");
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    chk("finhigh_still_run", {28'd0, state}, 32'd1);
    chk("finhigh_no_tx", tx_q.size(), 0);
    sys_fin = 1'b0;
    rdy_mode = 2;
    dump_and_check("finhigh");

    // Reset after a partial word; the stray byte must not reach memory
    do_reset();
    old0 = ram[0];
    send(8'hAA, 2);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_mem_kept", {16'd0, ram[0]}, {16'd0, old0});
    wr_q.delete();
    flsh_cycles = 0;
    bytes_in[0] = 8'h34; bytes_in[1] = 8'h12; bytes_in[2] = 8'h78; bytes_in[3] = 8'h56;
    load_and_check(-2, "midrst");
    wr_q.delete();
    for (int i = 0; i < 3; i++) send(8'h99, 1);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("run_rx_no_write", wr_q.size(), 0);
    chk("run_rx_state", {28'd0, state}, 32'd1);
    $display("TXN midrst addr0=%0h", ram[0]);

    // Randomized bytes, gaps and ready pattern against the reference model
    for (int it = 0; it < 4; it++) begin
      do_reset();
      for (int i = 0; i < 4; i++) bytes_in[i] = 8'($urandom_range(0, 255));
      load_and_check(3, $sformatf("rnd%0d", it));
      rdy_mode = 1;
      dump_and_check($sformatf("rnd%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
